// File: rtl/pipelined_addsub_pkg.sv
// Shared constants and elaboration helpers for the pipelined adder/subtractor.
// The optional overflow output is enabled with PIPELINED_ADDSUB_OVF_EN.
package pipelined_addsub_pkg;

    localparam logic ADD = 1'b0;
    localparam logic SUB = 1'b1;

    function automatic int chunk_width(input int width, input int stages);
        if (stages < 1) begin
            return width;
        end
        return width / stages;
    endfunction

    // The carry chain must split into STAGES equal, non-empty chunks.
    function automatic bit params_legal(input int width, input int stages);
        if (width < 1 || stages < 1 || stages > width) begin
            return 1'b0;
        end
        return (width % stages) == 0;
    endfunction

endpackage

// File: rtl/pipelined_addsub_chunk_stage.sv
// One carry chunk of the pipelined adder: a gate-level ripple adder feeding a
// registered chunk result, carry and valid bit that hold while the pipe stalls.
module full_adder_gatelevel_module (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);
    assign sum  = a ^ b ^ cin;
    assign cout = (a & b) | (cin & (a ^ b));
endmodule

module addsub_chunk_stage_module #(
    parameter int CHUNK = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             adv,
    input  logic             in_valid,
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    output logic [CHUNK-1:0] sum,
    output logic             cout
);
    logic [CHUNK:0]   carry;
    logic [CHUNK-1:0] sum_comb;

    assign carry[0] = cin;

    for (genvar i = 0; i < CHUNK; i++) begin : g_bit
        full_adder_gatelevel_module u_fa (
            .a    (a[i]),
            .b    (b[i]),
            .cin  (carry[i]),
            .sum  (sum_comb[i]),
            .cout (carry[i+1])
        );
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            sum       <= '0;
            cout      <= 1'b0;
        end else if (adv) begin
            out_valid <= in_valid;
            sum       <= sum_comb;
            cout      <= carry[CHUNK];
        end
    end

endmodule

// File: rtl/pipelined_addsub_module.sv
// Pipelined two's-complement add/subtract with valid/ready on both sides.
// Define PIPELINED_ADDSUB_OVF_EN to add the signed-overflow output ovf.
module pipelined_addsub_module
    import pipelined_addsub_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int STAGES = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout
`ifdef PIPELINED_ADDSUB_OVF_EN
    ,
    output logic             ovf
`endif
);
    localparam int CHUNK = chunk_width(WIDTH, STAGES);

    if (!params_legal(WIDTH, STAGES)) begin : g_param_check
        $error("pipelined_addsub_module: illegal WIDTH=%0d STAGES=%0d", WIDTH, STAGES);
    end

    logic             adv;
    logic [WIDTH-1:0] b_eff;
    logic             carry_in;

    // Whole pipe advances together; a blocked output freezes every stage.
    assign adv      = !out_valid || out_ready;
    assign in_ready = adv && !rst;
    assign b_eff    = (sub == SUB) ? ~b : b;
    assign carry_in = cin ^ sub;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        localparam int SRC_W = WIDTH - k * CHUNK;

        logic [SRC_W-1:0] src_a;
        logic [SRC_W-1:0] src_b;
        logic             src_c;
        logic             src_v;
        logic [CHUNK-1:0] res;
        logic             res_c;
        logic             res_v;

        if (k == 0) begin : g_src
            assign src_a = a;
            assign src_b = b_eff;
            assign src_c = carry_in;
            assign src_v = in_valid;
        end else begin : g_src
            assign src_a = g_stage[k-1].g_skew.a_hi;
            assign src_b = g_stage[k-1].g_skew.b_hi;
            assign src_c = g_stage[k-1].res_c;
            assign src_v = g_stage[k-1].res_v;
        end

        addsub_chunk_stage_module #(
            .CHUNK (CHUNK)
        ) u_chunk (
            .clk       (clk),
            .rst       (rst),
            .adv       (adv),
            .in_valid  (src_v),
            .a         (src_a[CHUNK-1:0]),
            .b         (src_b[CHUNK-1:0]),
            .cin       (src_c),
            .out_valid (res_v),
            .sum       (res),
            .cout      (res_c)
        );

        // Operand bits not yet consumed ride along to the following stages.
        if (k < STAGES - 1) begin : g_skew
            logic [SRC_W-CHUNK-1:0] a_hi;
            logic [SRC_W-CHUNK-1:0] b_hi;

            always_ff @(posedge clk) begin
                if (rst) begin
                    a_hi <= '0;
                    b_hi <= '0;
                end else if (adv) begin
                    a_hi <= src_a[SRC_W-1:CHUNK];
                    b_hi <= src_b[SRC_W-1:CHUNK];
                end
            end
        end

        // Finished low result chunks, kept aligned with this stage's chunk.
        if (k > 0) begin : g_lo
            logic [k*CHUNK-1:0] lo;
            logic [k*CHUNK-1:0] lo_next;

            if (k == 1) begin : g_first
                assign lo_next = g_stage[0].res;
            end else begin : g_rest
                assign lo_next = {g_stage[k-1].res, g_stage[k-1].g_lo.lo};
            end

            always_ff @(posedge clk) begin
                if (rst) begin
                    lo <= '0;
                end else if (adv) begin
                    lo <= lo_next;
                end
            end
        end
    end

    if (STAGES == 1) begin : g_out
        assign sum = g_stage[0].res;
    end else begin : g_out
        assign sum = {g_stage[STAGES-1].res, g_stage[STAGES-1].g_lo.lo};
    end

    assign cout      = g_stage[STAGES-1].res_c;
    assign out_valid = g_stage[STAGES-1].res_v;

`ifdef PIPELINED_ADDSUB_OVF_EN
    logic a_msb;
    logic b_msb;

    // Operand sign bits captured alongside the top chunk for overflow.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_msb <= 1'b0;
            b_msb <= 1'b0;
        end else if (adv) begin
            a_msb <= g_stage[STAGES-1].src_a[CHUNK-1];
            b_msb <= g_stage[STAGES-1].src_b[CHUNK-1];
        end
    end

    assign ovf = (a_msb == b_msb) && (sum[WIDTH-1] != a_msb);
`endif

endmodule

// File: tb/tb_pipelined_addsub_module.sv
// Directed and randomised checks of pipelined_addsub_module, plus 8-bit corner
// configurations; ovf checks are compiled in with PIPELINED_ADDSUB_OVF_EN.
module tb_pipelined_addsub_module;
    import pipelined_addsub_pkg::*;

    localparam int WIDTH  = 32;
    localparam int STAGES = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;

    logic       c_valid;
    logic [7:0] c_a;
    logic [7:0] c_b;
    logic       c_cin;
    logic       c_sub;
    logic       c_out_ready;
    logic       c1_in_ready;
    logic       c1_out_valid;
    logic [7:0] c1_sum;
    logic       c1_cout;
    logic       c8_in_ready;
    logic       c8_out_valid;
    logic [7:0] c8_sum;
    logic       c8_cout;

`ifdef PIPELINED_ADDSUB_OVF_EN
    logic ovf;
    logic c1_ovf;
    logic c8_ovf;
`endif

    int checks = 0;
    int passed = 0;

    pipelined_addsub_module #(.WIDTH(WIDTH), .STAGES(STAGES)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .cin(cin), .sub(sub),
        .out_valid(out_valid), .out_ready(out_ready), .sum(sum), .cout(cout)
`ifdef PIPELINED_ADDSUB_OVF_EN
        , .ovf(ovf)
`endif
    );

    pipelined_addsub_module #(.WIDTH(8), .STAGES(1)) dut_s1 (
        .clk(clk), .rst(rst), .in_valid(c_valid), .in_ready(c1_in_ready),
        .a(c_a), .b(c_b), .cin(c_cin), .sub(c_sub),
        .out_valid(c1_out_valid), .out_ready(c_out_ready), .sum(c1_sum), .cout(c1_cout)
`ifdef PIPELINED_ADDSUB_OVF_EN
        , .ovf(c1_ovf)
`endif
    );

    pipelined_addsub_module #(.WIDTH(8), .STAGES(8)) dut_s8 (
        .clk(clk), .rst(rst), .in_valid(c_valid), .in_ready(c8_in_ready),
        .a(c_a), .b(c_b), .cin(c_cin), .sub(c_sub),
        .out_valid(c8_out_valid), .out_ready(c_out_ready), .sum(c8_sum), .cout(c8_cout)
`ifdef PIPELINED_ADDSUB_OVF_EN
        , .ovf(c8_ovf)
`endif
    );

    // Offers one beat into an empty pipe and counts edges until the result shows.
    task automatic run_beat(input logic [WIDTH-1:0] va, input logic [WIDTH-1:0] vb,
                            input logic vcin, input logic vsub, output int lat);
        @(negedge clk);
        a = va; b = vb; cin = vcin; sub = vsub; in_valid = 1'b1;
        @(posedge clk);
        lat = 1;
        @(negedge clk);
        in_valid = 1'b0;
        while (!out_valid && lat < 20) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        a = '0; b = '0; cin = 1'b0; sub = ADD;
        c_valid = 1'b0; c_a = '0; c_b = '0; c_cin = 1'b0; c_sub = ADD; c_out_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++; if (in_ready !== 1'b0) $display("[TB] FAIL reset_in_ready: got %b, expected 0", in_ready); else passed++;
        checks++; if (out_valid !== 1'b0) $display("[TB] FAIL reset_out_valid: got %b, expected 0", out_valid); else passed++;
        checks++; if (sum !== '0) $display("[TB] FAIL reset_sum: got %h, expected 0", sum); else passed++;
        checks++; if (cout !== 1'b0) $display("[TB] FAIL reset_cout: got %b, expected 0", cout); else passed++;
        rst = 1'b0;
        #1;
        checks++; if (in_ready !== 1'b1) $display("[TB] FAIL post_reset_in_ready: got %b, expected 1", in_ready); else passed++;
    endtask

    task automatic test_add();
        int lat;
        run_beat(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, ADD, lat);
        checks++; if (lat != STAGES) $display("[TB] FAIL add_wrap_latency: got %0d, expected %0d", lat, STAGES); else passed++;
        checks++; if (sum !== 32'h0000_0000) $display("[TB] FAIL add_wrap_sum: got %h, expected 00000000", sum); else passed++;
        checks++; if (cout !== 1'b1) $display("[TB] FAIL add_wrap_cout: got %b, expected 1", cout); else passed++;
        run_beat(32'h1234_5678, 32'h0FED_CBA9, 1'b1, ADD, lat);
        checks++; if (sum !== 32'h2222_2222) $display("[TB] FAIL add_mixed_sum: got %h, expected 22222222", sum); else passed++;
        checks++; if (cout !== 1'b0) $display("[TB] FAIL add_mixed_cout: got %b, expected 0", cout); else passed++;
        run_beat(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, ADD, lat);
        checks++; if (sum !== 32'hFFFF_FFFF) $display("[TB] FAIL add_max_sum: got %h, expected ffffffff", sum); else passed++;
        checks++; if (cout !== 1'b1) $display("[TB] FAIL add_max_cout: got %b, expected 1", cout); else passed++;
    endtask

    task automatic test_sub();
        int lat;
        run_beat(32'd5, 32'd7, 1'b0, SUB, lat);
        checks++; if (lat != STAGES) $display("[TB] FAIL sub_latency: got %0d, expected %0d", lat, STAGES); else passed++;
        checks++; if (sum !== 32'hFFFF_FFFE) $display("[TB] FAIL sub_neg_sum: got %h, expected fffffffe", sum); else passed++;
        checks++; if (cout !== 1'b0) $display("[TB] FAIL sub_neg_cout: got %b, expected 0", cout); else passed++;
        run_beat(32'd7, 32'd5, 1'b1, SUB, lat);
        checks++; if (sum !== 32'h0000_0001) $display("[TB] FAIL sub_borrow_sum: got %h, expected 00000001", sum); else passed++;
        checks++; if (cout !== 1'b1) $display("[TB] FAIL sub_borrow_cout: got %b, expected 1", cout); else passed++;
    endtask

`ifdef PIPELINED_ADDSUB_OVF_EN
    task automatic test_ovf();
        int lat;
        run_beat(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, ADD, lat);
        checks++; if (sum !== 32'h8000_0000) $display("[TB] FAIL ovf_add_sum: got %h, expected 80000000", sum); else passed++;
        checks++; if (ovf !== 1'b1) $display("[TB] FAIL ovf_add_flag: got %b, expected 1", ovf); else passed++;
        checks++; if (cout !== 1'b0) $display("[TB] FAIL ovf_add_cout: got %b, expected 0", cout); else passed++;
        run_beat(32'h8000_0000, 32'h0000_0001, 1'b0, SUB, lat);
        checks++; if (sum !== 32'h7FFF_FFFF) $display("[TB] FAIL ovf_sub_sum: got %h, expected 7fffffff", sum); else passed++;
        checks++; if (ovf !== 1'b1) $display("[TB] FAIL ovf_sub_flag: got %b, expected 1", ovf); else passed++;
        run_beat(32'h0000_0001, 32'h0000_0001, 1'b0, ADD, lat);
        checks++; if (ovf !== 1'b0) $display("[TB] FAIL ovf_none_flag: got %b, expected 0", ovf); else passed++;
    endtask
`endif

    task automatic test_back_to_back();
        logic [WIDTH-1:0] exp_sum_q[$];
        logic             exp_cout_q[$];
        logic [WIDTH-1:0] held_sum;
        logic [WIDTH-1:0] exp_sum;
        logic             held_cout;
        logic             exp_cout;
        logic             was_stalled;
        logic             accepted;
        logic [WIDTH:0]   r;
        int               sent;
        int               recv;
        int               cyc;
        sent = 0; recv = 0; cyc = 0; was_stalled = 1'b0;
        held_sum = '0; held_cout = 1'b0;
        @(negedge clk);
        a = $urandom; b = $urandom; cin = 1'($urandom_range(0, 1)); sub = 1'($urandom_range(0, 1));
        in_valid = 1'b1;
        while (recv < 64 && cyc < 2000) begin
            out_ready = 1'($urandom_range(0, 1));
            #1;
            if (was_stalled) begin
                checks++;
                if (out_valid !== 1'b1 || sum !== held_sum || cout !== held_cout)
                    $display("[TB] FAIL stall_hold: got v=%b %h/%b, expected v=1 %h/%b", out_valid, sum, cout, held_sum, held_cout);
                else passed++;
            end
            checks++;
            if (in_ready !== !(out_valid && !out_ready))
                $display("[TB] FAIL in_ready_rule: got %b with out_valid=%b out_ready=%b", in_ready, out_valid, out_ready);
            else passed++;
            if (out_valid && out_ready) begin
                checks++;
                if (exp_sum_q.size() == 0) begin
                    $display("[TB] FAIL b2b_extra_beat: got %h, expected no beat", sum);
                end else begin
                    exp_sum = exp_sum_q.pop_front();
                    exp_cout = exp_cout_q.pop_front();
                    if (sum !== exp_sum || cout !== exp_cout)
                        $display("[TB] FAIL b2b_result %0d: got %h/%b, expected %h/%b", recv, sum, cout, exp_sum, exp_cout);
                    else passed++;
                end
                recv++;
            end
            accepted = in_valid && in_ready;
            if (accepted) begin
                if (sub) begin
                    r = {1'b0, a} - {1'b0, b} - (WIDTH+1)'(cin);
                    exp_cout_q.push_back(~r[WIDTH]);
                end else begin
                    r = {1'b0, a} + {1'b0, b} + (WIDTH+1)'(cin);
                    exp_cout_q.push_back(r[WIDTH]);
                end
                exp_sum_q.push_back(r[WIDTH-1:0]);
                sent++;
            end
            was_stalled = out_valid && !out_ready;
            held_sum = sum;
            held_cout = cout;
            @(posedge clk);
            @(negedge clk);
            cyc++;
            if (accepted) begin
                if (sent < 64) begin
                    a = $urandom; b = $urandom; cin = 1'($urandom_range(0, 1)); sub = 1'($urandom_range(0, 1));
                end else begin
                    in_valid = 1'b0;
                end
            end
        end
        checks++;
        if (recv != 64 || exp_sum_q.size() != 0)
            $display("[TB] FAIL b2b_count: got %0d received %0d pending, expected 64 received 0 pending", recv, exp_sum_q.size());
        else passed++;
        in_valid = 1'b0;
        out_ready = 1'b1;
    endtask

    task automatic test_reset_mid();
        int stale;
        int lat;
        out_ready = 1'b1;
        @(negedge clk); a = 32'd1; b = 32'd2; cin = 1'b0; sub = ADD; in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk); a = 32'd3;
        @(posedge clk);
        @(negedge clk); a = 32'd5;
        @(posedge clk);
        @(negedge clk); in_valid = 1'b0; rst = 1'b1;
        #1;
        checks++; if (in_ready !== 1'b0) $display("[TB] FAIL mid_reset_in_ready: got %b, expected 0", in_ready); else passed++;
        @(posedge clk);
        @(negedge clk);
        checks++; if (out_valid !== 1'b0) $display("[TB] FAIL mid_reset_out_valid: got %b, expected 0", out_valid); else passed++;
        rst = 1'b0;
        stale = 0;
        for (int i = 0; i < 2 * STAGES; i++) begin
            @(posedge clk);
            @(negedge clk);
            if (out_valid) stale++;
        end
        checks++; if (stale != 0) $display("[TB] FAIL mid_reset_stale: got %0d, expected 0", stale); else passed++;
        run_beat(32'h0000_0100, 32'h0000_0023, 1'b1, ADD, lat);
        checks++; if (lat != STAGES) $display("[TB] FAIL after_reset_latency: got %0d, expected %0d", lat, STAGES); else passed++;
        checks++; if (sum !== 32'h0000_0124) $display("[TB] FAIL after_reset_sum: got %h, expected 00000124", sum); else passed++;
        checks++; if (cout !== 1'b0) $display("[TB] FAIL after_reset_cout: got %b, expected 0", cout); else passed++;
    endtask

    task automatic test_corner_configs();
        int       lat1;
        int       lat8;
        logic [7:0] s1;
        logic [7:0] s8;
        logic     co1;
        logic     co8;
        lat1 = -1; lat8 = -1; s1 = 8'hAA; s8 = 8'hAA; co1 = 1'b0; co8 = 1'b0;
        @(negedge clk);
        c_a = 8'hFF; c_b = 8'h01; c_cin = 1'b0; c_sub = ADD; c_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        c_valid = 1'b0;
        for (int cyc = 1; cyc <= 12; cyc++) begin
            if (c1_out_valid && lat1 < 0) begin lat1 = cyc; s1 = c1_sum; co1 = c1_cout; end
            if (c8_out_valid && lat8 < 0) begin lat8 = cyc; s8 = c8_sum; co8 = c8_cout; end
            @(posedge clk);
            @(negedge clk);
        end
        checks++; if (lat1 != 1) $display("[TB] FAIL s1_latency: got %0d, expected 1", lat1); else passed++;
        checks++; if (s1 !== 8'h00) $display("[TB] FAIL s1_sum: got %h, expected 00", s1); else passed++;
        checks++; if (co1 !== 1'b1) $display("[TB] FAIL s1_cout: got %b, expected 1", co1); else passed++;
        checks++; if (lat8 != 8) $display("[TB] FAIL s8_latency: got %0d, expected 8", lat8); else passed++;
        checks++; if (s8 !== 8'h00) $display("[TB] FAIL s8_sum: got %h, expected 00", s8); else passed++;
        checks++; if (co8 !== 1'b1) $display("[TB] FAIL s8_cout: got %b, expected 1", co8); else passed++;
    endtask

    initial begin
        test_reset();
        test_add();
        test_sub();
`ifdef PIPELINED_ADDSUB_OVF_EN
        test_ovf();
`endif
        test_back_to_back();
        test_reset_mid();
        test_corner_configs();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
